bist_response_analyzer: RTL and testbench

Session controller and response analyzer sitting directly downstream of the BIST datapath (LFSR pattern generators, ALU under test, golden-ROM comparator). It sequences the datapath through the enabled ALU operations and restarts the pattern generators and ROM address for each one. Each cycle it consumes the comparator's `match` bit and the raw 9-bit ALU response, counts mismatches, records the first failure and compacts all responses into a 16-bit MISR signature. It reports a pass/fail verdict at the end of the session.

---
 rtl/bist_response_analyzer.sv | 181 ++++++++++++++++++
 tb/tb_bist_response_analyzer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_response_analyzer.sv
// bist_response_analyzer
// Sequences the BIST datapath through every enabled ALU op, counts comparator
// mismatches, records the first failing (op, index) and compacts every ALU
// response into a 16-bit MISR. A pass/fail verdict is held in DONE.
module bist_response_analyzer #(
   parameter int PATTERNS = 256,
   parameter int COUNT_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [7:0]         op_mask,
   input  logic               match,
   input  logic [8:0]         alu_data,
   output logic               bist_reset,
   output logic [2:0]         alu_sel,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [COUNT_W-1:0] fail_count,
   output logic               first_fail_valid,
   output logic [2:0]         first_fail_op,
   output logic [7:0]         first_fail_idx,
   output logic [15:0]        signature
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_INIT,
      S_RUN,
      S_DONE
   } state_t;

   // The run index is 8 bits wide; PATTERNS = 256 ends on index 255.
   localparam logic [7:0]         LAST_IDX = 8'(PATTERNS - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
   localparam logic [15:0]        MISR_SEED = 16'hFFFF;
   localparam logic [15:0]        MISR_POLY = 16'h1021;

   state_t             r_state;
   logic [7:0]         r_mask;
   logic [7:0]         r_idx;
   logic               r_bist_reset;
   logic [2:0]         r_alu_sel;
   logic               r_busy;
   logic               r_done;
   logic               r_pass;
   logic [COUNT_W-1:0] r_fail_count;
   logic               r_ff_valid;
   logic [2:0]         r_ff_op;
   logic [7:0]         r_ff_idx;
   logic [15:0]        r_sig;

   logic               w_first_any;
   logic [2:0]         w_first_op;
   logic               w_next_any;
   logic [2:0]         w_next_op;
   logic               w_last;
   logic               w_fail_inc;
   logic [COUNT_W-1:0] w_cnt_nxt;
   logic [15:0]        w_sig_nxt;

   // Lowest enabled op in the incoming mask, used when a session is accepted.
   always_comb begin
      w_first_any = 1'b0;
      w_first_op  = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (op_mask[i]) begin
            w_first_any = 1'b1;
            w_first_op  = 3'(i);
         end
      end
   end

   // Next enabled op strictly above the current one in the latched mask.
   always_comb begin
      w_next_any = 1'b0;
      w_next_op  = r_alu_sel;
      for (int i = 7; i >= 0; i--) begin
         if (r_mask[i] && (i > int'(r_alu_sel))) begin
            w_next_any = 1'b1;
            w_next_op  = 3'(i);
         end
      end
   end

   // Per-RUN-cycle datapath: saturating fail count and MISR step.
   always_comb begin
      w_last     = (r_idx == LAST_IDX);
      w_fail_inc = !match && (r_fail_count != CNT_MAX);
      w_cnt_nxt  = r_fail_count + (w_fail_inc ? COUNT_W'(1) : COUNT_W'(0));
      w_sig_nxt  = ({r_sig[14:0], 1'b0} ^ (r_sig[15] ? MISR_POLY : 16'h0000))
                   ^ {7'b0, alu_data};
   end

   // Session FSM; every output is a register written here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_mask       <= 8'd0;
         r_idx        <= 8'd0;
         r_bist_reset <= 1'b1;
         r_alu_sel    <= 3'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_fail_count <= '0;
         r_ff_valid   <= 1'b0;
         r_ff_op      <= 3'd0;
         r_ff_idx     <= 8'd0;
         r_sig        <= MISR_SEED;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_mask       <= op_mask;
                  r_fail_count <= '0;
                  r_ff_valid   <= 1'b0;
                  r_ff_op      <= 3'd0;
                  r_ff_idx     <= 8'd0;
                  r_sig        <= MISR_SEED;
                  r_bist_reset <= 1'b1;
                  if (w_first_any) begin
                     r_state   <= S_INIT;
                     r_alu_sel <= w_first_op;
                     r_busy    <= 1'b1;
                     r_done    <= 1'b0;
                     r_pass    <= 1'b0;
                  end else begin
                     // Nothing to test: an empty session trivially passes.
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_pass  <= 1'b1;
                  end
               end
            end
            S_INIT: begin
               r_state      <= S_RUN;
               r_bist_reset <= 1'b0;
               r_idx        <= 8'd0;
            end
            S_RUN: begin
               r_fail_count <= w_cnt_nxt;
               r_sig        <= w_sig_nxt;
               r_idx        <= r_idx + 8'd1;
               if (!match && !r_ff_valid) begin
                  r_ff_valid <= 1'b1;
                  r_ff_op    <= r_alu_sel;
                  r_ff_idx   <= r_idx;
               end
               if (w_last) begin
                  r_bist_reset <= 1'b1;
                  if (w_next_any) begin
                     r_state   <= S_INIT;
                     r_alu_sel <= w_next_op;
                  end else begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_pass  <= (w_cnt_nxt == '0);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bist_reset       = r_bist_reset;
   assign alu_sel          = r_alu_sel;
   assign busy             = r_busy;
   assign done             = r_done;
   assign pass             = r_pass;
   assign fail_count       = r_fail_count;
   assign first_fail_valid = r_ff_valid;
   assign first_fail_op    = r_ff_op;
   assign first_fail_idx   = r_ff_idx;
   assign signature        = r_sig;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Bench for bist_response_analyzer: three instances (PATTERNS/COUNT_W
// variants) driven by a small datapath model, table-driven sessions with a
// scoreboard queue, plus a hand-written mid-RUN reset sequence.
module tb_bist_response_analyzer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       start_a, start_b, start_c;
   logic [7:0] op_mask;
   logic       match;
   logic [8:0] alu_data;

   logic a_br, a_busy, a_done, a_pass, a_ffv;
   logic [2:0] a_sel, a_ffop;
   logic [7:0] a_ffidx;
   logic [15:0] a_cnt, a_sig;
   logic b_br, b_busy, b_done, b_pass, b_ffv;
   logic [2:0] b_sel, b_ffop;
   logic [7:0] b_ffidx;
   logic [15:0] b_cnt, b_sig;
   logic c_br, c_busy, c_done, c_pass, c_ffv;
   logic [2:0] c_sel, c_ffop;
   logic [7:0] c_ffidx;
   logic [3:0] c_cnt;
   logic [15:0] c_sig;

   bist_response_analyzer #(.PATTERNS(256), .COUNT_W(16)) u_a (
      .clk(clk), .reset(reset), .start(start_a), .op_mask(op_mask), .match(match),
      .alu_data(alu_data), .bist_reset(a_br), .alu_sel(a_sel), .busy(a_busy),
      .done(a_done), .pass(a_pass), .fail_count(a_cnt), .first_fail_valid(a_ffv),
      .first_fail_op(a_ffop), .first_fail_idx(a_ffidx), .signature(a_sig));

   bist_response_analyzer #(.PATTERNS(1), .COUNT_W(16)) u_b (
      .clk(clk), .reset(reset), .start(start_b), .op_mask(op_mask), .match(match),
      .alu_data(alu_data), .bist_reset(b_br), .alu_sel(b_sel), .busy(b_busy),
      .done(b_done), .pass(b_pass), .fail_count(b_cnt), .first_fail_valid(b_ffv),
      .first_fail_op(b_ffop), .first_fail_idx(b_ffidx), .signature(b_sig));

   bist_response_analyzer #(.PATTERNS(32), .COUNT_W(4)) u_c (
      .clk(clk), .reset(reset), .start(start_c), .op_mask(op_mask), .match(match),
      .alu_data(alu_data), .bist_reset(c_br), .alu_sel(c_sel), .busy(c_busy),
      .done(c_done), .pass(c_pass), .fail_count(c_cnt), .first_fail_valid(c_ffv),
      .first_fail_op(c_ffop), .first_fail_idx(c_ffidx), .signature(c_sig));

   // View of whichever instance is under test.
   int sel_dut = 0;
   logic s_br, s_busy, s_done, s_pass, s_ffv;
   logic [2:0] s_sel, s_ffop;
   logic [7:0] s_ffidx;
   logic [15:0] s_cnt, s_sig;

   always_comb begin
      s_br = a_br; s_sel = a_sel; s_busy = a_busy; s_done = a_done; s_pass = a_pass;
      s_cnt = a_cnt; s_ffv = a_ffv; s_ffop = a_ffop; s_ffidx = a_ffidx; s_sig = a_sig;
      if (sel_dut == 1) begin
         s_br = b_br; s_sel = b_sel; s_busy = b_busy; s_done = b_done; s_pass = b_pass;
         s_cnt = b_cnt; s_ffv = b_ffv; s_ffop = b_ffop; s_ffidx = b_ffidx; s_sig = b_sig;
      end else if (sel_dut == 2) begin
         s_br = c_br; s_sel = c_sel; s_busy = c_busy; s_done = c_done; s_pass = c_pass;
         s_cnt = {12'd0, c_cnt}; s_ffv = c_ffv; s_ffop = c_ffop; s_ffidx = c_ffidx;
         s_sig = c_sig;
      end
   end

   // Datapath model: ROM/LFSR index restarts under bist_reset.
   bit all_fail = 1'b0, zero_data = 1'b0;
   int f0_op = -1, f0_idx = 0, f1_op = -1, f1_idx = 0;
   int cnt = 0;

   function automatic logic [8:0] dat(int op, int k);
      return 9'(((k * 37) + (op * 11)) ^ 'h0A5);
   endfunction

   always @(posedge clk) begin
      if (s_br) cnt <= 0;
      else      cnt <= cnt + 1;
   end

   always @(negedge clk) begin
      match = !(all_fail || (int'(s_sel) == f0_op && cnt == f0_idx) ||
                (int'(s_sel) == f1_op && cnt == f1_idx));
      alu_data = zero_data ? 9'd0 : dat(int'(s_sel), cnt);
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      int          dut;
      logic [7:0]  mask;
      bit          all_fail;
      bit          zero_data;
      bit          poke;
      bit          chk_sig;
      int          f0_op, f0_idx, f1_op, f1_idx;
      logic [15:0] cnt;
      logic        pass;
      logic        ffv;
      logic [2:0]  ffop;
      logic [7:0]  ffidx;
      logic [15:0] sig_fixed;
   } vec_t;

   typedef struct {
      int          lat;
      int          lowcyc;
      logic [15:0] cnt;
      logic        pass, ffv;
      logic [2:0]  ffop;
      logic [7:0]  ffidx;
      logic [15:0] sig;
   } exp_t;

   exp_t sb[$];
   vec_t vt[8];

   function automatic int pat(int d);
      return (d == 0) ? 256 : (d == 1) ? 1 : 32;
   endfunction

   task automatic set_start(int d, logic v);
      if (d == 0) start_a = v;
      else if (d == 1) start_b = v;
      else start_c = v;
   endtask

   task automatic run_vec(vec_t v);
      int P, E, n, low, selbad, lim;
      int ops[$];
      logic [15:0] sig;
      exp_t e;
      sel_dut = v.dut; P = pat(v.dut);
      all_fail = v.all_fail; zero_data = v.zero_data;
      f0_op = v.f0_op; f0_idx = v.f0_idx; f1_op = v.f1_op; f1_idx = v.f1_idx;
      sig = 16'hFFFF;
      for (int op = 0; op < 8; op++) begin
         if (v.mask[op]) begin
            ops.push_back(op);
            for (int k = 0; k < P; k++) begin
               sig = ({sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000)) ^
                     {7'b0, (v.zero_data ? 9'd0 : dat(op, k))};
            end
         end
      end
      E = ops.size();
      e.lat = E * (P + 1); e.lowcyc = E * P; e.cnt = v.cnt; e.pass = v.pass;
      e.ffv = v.ffv; e.ffop = v.ffop; e.ffidx = v.ffidx; e.sig = sig;
      sb.push_back(e);
      @(negedge clk);
      op_mask = v.mask;
      set_start(v.dut, 1'b1);
      @(posedge clk); #1;
      set_start(v.dut, 1'b0);
      n = 0; low = 0; selbad = 0; lim = e.lat + 10;
      while (!s_done && n < lim) begin
         @(posedge clk); #1;
         n++;
         if (v.poke && n == 20) begin
            set_start(v.dut, 1'b1); op_mask = 8'hFF;
         end
         if (v.poke && n == 21) set_start(v.dut, 1'b0);
         if (!s_br) begin
            if (low / P < E) begin
               if (int'(s_sel) != ops[low / P]) selbad++;
            end else selbad++;
            low++;
         end
      end
      e = sb.pop_front();
      chk($sformatf("v%0d done_latency", v.dut), n, e.lat);
      chk("pass", {31'd0, s_pass}, {31'd0, e.pass});
      chk("fail_count", {16'd0, s_cnt}, {16'd0, e.cnt});
      chk("first_fail_valid", {31'd0, s_ffv}, {31'd0, e.ffv});
      chk("first_fail_op", {29'd0, s_ffop}, {29'd0, e.ffop});
      chk("first_fail_idx", {24'd0, s_ffidx}, {24'd0, e.ffidx});
      chk("signature", {16'd0, s_sig}, {16'd0, e.sig});
      if (v.chk_sig) chk("signature_const", {16'd0, s_sig}, {16'd0, v.sig_fixed});
      chk("bist_reset_low_cycles", low, e.lowcyc);
      chk("alu_sel_during_run", selbad, 0);
      chk("busy_in_done", {31'd0, s_busy}, 32'd0);
      chk("bist_reset_in_done", {31'd0, s_br}, 32'd1);
      @(posedge clk); #1;
      chk("done_held", {31'd0, s_done}, 32'd1);
      chk("signature_held", {16'd0, s_sig}, {16'd0, e.sig});
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, "_bist_reset"}, {31'd0, a_br}, 32'd1);
      chk({tag, "_alu_sel"}, {29'd0, a_sel}, 32'd0);
      chk({tag, "_busy"}, {31'd0, a_busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, a_done}, 32'd0);
      chk({tag, "_pass"}, {31'd0, a_pass}, 32'd0);
      chk({tag, "_fail_count"}, {16'd0, a_cnt}, 32'd0);
      chk({tag, "_ffv"}, {31'd0, a_ffv}, 32'd0);
      chk({tag, "_ffop"}, {29'd0, a_ffop}, 32'd0);
      chk({tag, "_ffidx"}, {24'd0, a_ffidx}, 32'd0);
      chk({tag, "_signature"}, {16'd0, a_sig}, 32'h0000FFFF);
   endtask

   initial begin
      int n;
      //          dut mask   af zd pk cs  f0op f0i f1op f1i  cnt pass ffv op idx sig
      vt[0] = '{0, 8'h01, 0, 0, 0, 0, -1, 0,  -1, 0,   16'd0,  1, 0, 3'd0, 8'd0,   16'h0};
      vt[1] = '{0, 8'h01, 0, 0, 0, 0,  0, 37,  0, 200, 16'd2,  0, 1, 3'd0, 8'd37,  16'h0};
      vt[2] = '{0, 8'hA0, 0, 0, 1, 0,  7, 0,  -1, 0,   16'd1,  0, 1, 3'd7, 8'd0,   16'h0};
      vt[3] = '{1, 8'h01, 0, 1, 0, 1, -1, 0,  -1, 0,   16'd0,  1, 0, 3'd0, 8'd0,   16'hEFDF};
      vt[4] = '{1, 8'h00, 0, 0, 0, 1, -1, 0,  -1, 0,   16'd0,  1, 0, 3'd0, 8'd0,   16'hFFFF};
      vt[5] = '{2, 8'h01, 1, 0, 0, 0, -1, 0,  -1, 0,   16'd15, 0, 1, 3'd0, 8'd0,   16'h0};
      vt[6] = '{2, 8'hFF, 1, 0, 0, 0, -1, 0,  -1, 0,   16'd15, 0, 1, 3'd0, 8'd0,   16'h0};
      vt[7] = '{0, 8'h12, 0, 0, 0, 0,  4, 255, 1, 3,   16'd2,  0, 1, 3'd1, 8'd3,   16'h0};

      reset = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      op_mask = 8'h00; match = 1'b1; alu_data = 9'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("por");
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_done", {31'd0, a_done}, 32'd0);

      for (int i = 0; i < 8; i++) run_vec(vt[i]);

      // Mid-RUN reset: fail at index 50, reset asserted at index 100.
      sel_dut = 0; all_fail = 1'b0; zero_data = 1'b0;
      f0_op = 0; f0_idx = 50; f1_op = -1;
      @(negedge clk);
      op_mask = 8'h01; start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      n = 0;
      while (!(cnt == 100 && !a_br) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reach_run_idx100", {31'd0, (cnt == 100 && !a_br)}, 32'd1);
      chk("pre_reset_fail_count", {16'd0, a_cnt}, 32'd1);
      reset = 1'b0;
      #1;
      chk_reset_vals("async");
      repeat (3) @(negedge clk);
      chk_reset_vals("held");
      reset = 1'b1;
      @(negedge clk);
      run_vec(vt[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
